ifft_addr_gen: RTL and testbench
================================

Name: ifft_addr_gen

Overview:
- Control and address generator for the 16-point, 16-bit fixed-point radix-2 DIT IFFT core.
- Sits directly upstream of the core's 4-bit address mux:
  - drives the mux's input-0 with the bit-reversed load address;
  - drives the mux's input-1 with the butterfly or unload address;
  - drives the mux select.
- Sequences the LOAD, COMPUTE (4 stages x 8 butterflies) and UNLOAD phases, and emits twiddle index, stage number, strobes and a done pulse.

Parameters:
- BF_LAT, 2, butterfly datapath pipeline depth; idle flush cycles inserted after each stage (0..7 legal).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- in_valid  input  1  input sample present this cycle (LOAD phase).
- out_ready  input  1  downstream accepts an output sample this cycle (UNLOAD phase).
- load_addr  output  4  bit-reversed write address; feeds the mux input-0.
- bfly_addr_a  output  4  butterfly upper address, or natural-order read address in UNLOAD; feeds the mux input-1.
- bfly_addr_b  output  4  butterfly lower address (addr_a + span).
- tw_addr  output  3  twiddle ROM index n of W16^n.
- addr_sel  output  1  mux select: 0 in LOAD, 1 in COMPUTE/UNLOAD.
- stage  output  2  current DIT stage 0..3.
- wr_en  output  1  memory write strobe (LOAD sample accepted).
- bf_en  output  1  butterfly issue strobe.
- rd_en  output  1  UNLOAD read strobe.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final output sample.

Behaviour:
- All outputs are registered.
- Async reset (rst_n=0) applies immediately, mid-frame included:
  - state=IDLE;
  - every output = 0;
  - all counters = 0.
- States: IDLE, LOAD, COMP, FLUSH, UNLOAD, DONE.
- IDLE:
  - start=1 -> LOAD next cycle; busy=1 from that cycle.
  - in_valid and out_ready are ignored.
- LOAD:
  - addr_sel=0.
  - A 4-bit counter i (0..15) advances only on in_valid=1.
  - In the cycle after a sample is accepted: wr_en=1 and load_addr = bitrev(i), i.e. {i[0],i[1],i[2],i[3]}.
  - With no in_valid: wr_en=0 and load_addr holds.
  - After the 16th accepted sample -> COMP with s=0, k=0.
- COMP:
  - addr_sel=1, bf_en=1 every cycle; k counts 0..7.
  - Per butterfly:
    - span = 1<<s
    - pos = k & (span-1)
    - grp = k >> s
    - bfly_addr_a = grp*2*span + pos
    - bfly_addr_b = bfly_addr_a + span
    - tw_addr = pos << (3-s)
  - All arithmetic is 4-bit unsigned and cannot overflow.
  - At k=7 -> FLUSH.
- FLUSH:
  - bf_en=0 for BF_LAT cycles; addresses hold.
  - Then, if s<3: s+1, k=0, back to COMP.
  - Else -> UNLOAD.
  - With BF_LAT=0: no idle cycle; stages are back-to-back.
- UNLOAD:
  - addr_sel=1, tw_addr=0, counter j counts 0..15 in natural order.
  - Each cycle with out_ready=1: rd_en=1, bfly_addr_a=j, j increments.
  - out_ready=0: rd_en=0 and the address holds.
  - After j=15 is read -> DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
  - start asserted in the DONE cycle is ignored.
- start while busy=1 is ignored and has no effect on counters.
- Latency with continuous valid/ready: 16 + 4*(8+BF_LAT) + 16 + 1 cycles from start acceptance to done (73 cycles at BF_LAT=2).

Test Plan:
1. Reset then start, in_valid held 16 cycles -> load_addr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with wr_en=1 and addr_sel=0 each cycle.
2. COMP at BF_LAT=2, no stalls:
   - stage0 -> a/b = 0/1, 2/3 .. 14/15, tw all 0.
   - stage1 -> a = 0,1,4,5,8,9,12,13, b = a+2, tw = 0,4,0,4..
   - stage3 -> a = 0..7, b = a+8, tw = 0..7.
   - Exactly 2 bf_en=0 cycles between stages.
3. in_valid toggled 1,0,0,1,... during LOAD -> wr_en only on accepted samples, load_addr holds across gaps, COMP entered only after the 16th accept.
4. out_ready low for 3 cycles mid-UNLOAD at j=5 -> rd_en=0 and bfly_addr_a=5 held; j=15 read followed by done pulse of width 1; total latency 73 + 3 cycles.
5. start pulsed during COMP stage 2 -> ignored, sequence unchanged.
6. rst_n driven low asynchronously mid-FLUSH -> all outputs 0 immediately; a subsequent start restarts cleanly from load_addr=0.

Source files
------------

// File: rtl/ifft_addr_gen.sv
// ifft_addr_gen: LOAD / COMPUTE / UNLOAD sequencer and address generator for a
// 16-point radix-2 DIT IFFT memory; every output comes straight from a flop.
module ifft_addr_gen #(
  parameter int BF_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic [3:0] load_addr,
  output logic [3:0] bfly_addr_a,
  output logic [3:0] bfly_addr_b,
  output logic [2:0] tw_addr,
  output logic       addr_sel,
  output logic [1:0] stage,
  output logic       wr_en,
  output logic       bf_en,
  output logic       rd_en,
  output logic       busy,
  output logic       done
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] COMP   = 3'd2;
  localparam logic [2:0] FLUSH  = 3'd3;
  localparam logic [2:0] UNLOAD = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0] state_q, state_d;
  logic [3:0] i_q, i_d, j_q, j_d;
  logic [2:0] k_q, k_d, f_q, f_d;
  logic [1:0] s_q, s_d;
  logic [3:0] load_addr_q, load_addr_d, a_q, a_d, b_q, b_d;
  logic [2:0] tw_q, tw_d;
  logic [1:0] stage_q, stage_d;
  logic       sel_q, sel_d, wr_q, wr_d, bf_q, bf_d, rd_q, rd_d, busy_q, busy_d, done_q, done_d;

  logic [3:0] span, a_c;
  logic [2:0] pos, grp, tw_c;

  // butterfly geometry for stage s, butterfly k
  assign span = 4'd1 << s_q;
  assign pos  = k_q & 3'(span - 4'd1);
  assign grp  = k_q >> s_q;
  assign a_c  = ({grp, 1'b0} << s_q) + {1'b0, pos};
  assign tw_c = pos << (2'd3 - s_q);

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    f_d         = f_q;
    s_d         = s_q;
    load_addr_d = load_addr_q;
    a_d         = a_q;
    b_d         = b_q;
    tw_d        = tw_q;
    stage_d     = stage_q;
    sel_d       = sel_q;
    wr_d        = 1'b0;
    bf_d        = 1'b0;
    rd_d        = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        // done_q marks the pulse cycle, in which a new start is not honoured
        if (start && !done_q) begin
          state_d = LOAD;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          f_d     = '0;
          s_d     = '0;
          sel_d   = 1'b0;
        end
      end
      LOAD: begin
        sel_d = 1'b0;
        if (in_valid) begin
          wr_d        = 1'b1;
          load_addr_d = {i_q[0], i_q[1], i_q[2], i_q[3]};
          i_d         = i_q + 4'd1;
          state_d     = (i_q == 4'd15) ? COMP : LOAD;
        end
      end
      COMP: begin
        sel_d   = 1'b1;
        bf_d    = 1'b1;
        a_d     = a_c;
        b_d     = a_c + span;
        tw_d    = tw_c;
        stage_d = s_q;
        k_d     = k_q + 3'd1;
        f_d     = '0;
        if (k_q == 3'd7) begin
          state_d = (BF_LAT != 0) ? FLUSH : (s_q == 2'd3) ? UNLOAD : COMP;
          s_d     = (BF_LAT != 0) ? s_q : s_q + 2'd1;
        end
      end
      FLUSH: begin
        f_d = f_q + 3'd1;
        if (f_q == 3'(BF_LAT - 1)) begin
          state_d = (s_q == 2'd3) ? UNLOAD : COMP;
          s_d     = s_q + 2'd1;
        end
      end
      UNLOAD: begin
        sel_d = 1'b1;
        tw_d  = '0;
        if (out_ready) begin
          rd_d    = 1'b1;
          a_d     = j_q;
          j_d     = j_q + 4'd1;
          state_d = (j_q == 4'd15) ? DONE : UNLOAD;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        sel_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      f_q         <= '0;
      s_q         <= '0;
      load_addr_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tw_q        <= '0;
      stage_q     <= '0;
      sel_q       <= 1'b0;
      wr_q        <= 1'b0;
      bf_q        <= 1'b0;
      rd_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      f_q         <= f_d;
      s_q         <= s_d;
      load_addr_q <= load_addr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tw_q        <= tw_d;
      stage_q     <= stage_d;
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      bf_q        <= bf_d;
      rd_q        <= rd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign load_addr   = load_addr_q;
  assign bfly_addr_a = a_q;
  assign bfly_addr_b = b_q;
  assign tw_addr     = tw_q;
  assign addr_sel    = sel_q;
  assign stage       = stage_q;
  assign wr_en       = wr_q;
  assign bf_en       = bf_q;
  assign rd_en       = rd_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_ifft_addr_gen.sv
// tb_ifft_addr_gen: randomized scoreboard bench; the driver pushes the expected
// strobe stream per frame and a negedge monitor pops and compares it.
module tb_ifft_addr_gen;
  localparam int BF_LAT = 2;
  localparam int STG = 8 + BF_LAT;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] load_addr, bfly_addr_a, bfly_addr_b;
  logic [2:0] tw_addr;
  logic [1:0] stage;
  logic addr_sel, wr_en, bf_en, rd_en, busy, done;

  ifft_addr_gen #(.BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .out_ready(out_ready),
    .load_addr(load_addr), .bfly_addr_a(bfly_addr_a), .bfly_addr_b(bfly_addr_b),
    .tw_addr(tw_addr), .addr_sel(addr_sel), .stage(stage), .wr_en(wr_en),
    .bf_en(bf_en), .rd_en(rd_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // kind: 1 write, 2 butterfly, 4 read, 8 done
  typedef struct { int kind; int a; int b; int tw; int st; int first; int lat; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, pcyc = 0, start_pc = 0, last_load = 0, last_a = 0, last_bf = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_load_addr"}, load_addr, 0);
    chk({tag, "_addr_a"}, bfly_addr_a, 0);
    chk({tag, "_addr_b"}, bfly_addr_b, 0);
    chk({tag, "_tw"}, tw_addr, 0);
    chk({tag, "_sel"}, addr_sel, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_strobes"}, int'({done, rd_en, bf_en, wr_en}), 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  function automatic int bitrev(input int i);
    return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
  endfunction

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (wr_en || bf_en || rd_en || done) begin
        if (sb.size() == 0) chk("unexpected_strobe", int'({done, rd_en, bf_en, wr_en}), 0);
        else begin
          e = sb.pop_front();
          chk("strobe_kind", int'({done, rd_en, bf_en, wr_en}), e.kind);
          case (e.kind)
            1: begin
              chk("load_addr", load_addr, e.a);
              chk("load_sel", addr_sel, 0);
              chk("load_busy", busy, 1);
              last_load = e.a;
            end
            2: begin
              chk("bfly_a", bfly_addr_a, e.a);
              chk("bfly_b", bfly_addr_b, e.b);
              chk("bfly_tw", tw_addr, e.tw);
              chk("bfly_stage", stage, e.st);
              chk("bfly_sel", addr_sel, 1);
              if (e.first != 0 && e.st > 0) chk("flush_gap", pcyc - last_bf - 1, BF_LAT);
              last_bf = pcyc;
              last_a = e.a;
            end
            4: begin
              chk("unload_addr", bfly_addr_a, e.a);
              chk("unload_tw", tw_addr, 0);
              chk("unload_sel", addr_sel, 1);
              last_a = e.a;
            end
            default: begin
              chk("done_busy", busy, 0);
              chk("latency", pcyc - start_pc, e.lat);
            end
          endcase
        end
      end else if (busy) begin
        chk("load_addr_hold", load_addr, last_load);
        chk("addr_a_hold", bfly_addr_a, last_a);
      end
    end
  end

  // mode 0: continuous, 1: directed gaps/stall, 2: random, 3: random with reset mid-flush
  task automatic run_frame(input int mode, input bit poke);
    int acc = 0, rd = 0, e = 0, cend = -1, dend = -1, low = 0, s2;
    bit iv, rdy;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) sb.push_back('{1, bitrev(i), 0, 0, 0, 0, 0});
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 8; k++) begin
        int span = 1 << s;
        int pos = k % span;
        int a = (k / span) * 2 * span + pos;
        sb.push_back('{2, a, a + span, pos * (8 / span), s, int'(k == 0), 0});
      end
    for (int j = 0; j < 16; j++) sb.push_back('{4, j, 0, 0, 0, 0, 0});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_pc = pcyc;
    while (dend < 0 || e < dend) begin
      iv  = (mode >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      rdy = (mode >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (acc < 16) begin
        if (mode == 0) iv = 1'b1;
        else if (mode == 1) iv = (e % 3 == 0);
      end else if (cend >= 0 && e >= cend && rd < 16) begin
        if (mode == 0) rdy = 1'b1;
        else if (mode == 1) begin
          rdy = !(rd == 5 && low < 3);
          if (!rdy) low++;
        end
      end
      s2 = cend - 2 * STG + 1;
      start = poke && ((cend >= 0 && e + 1 >= s2 && e + 1 <= s2 + 7) ||
                       (dend >= 0 && e + 1 == dend) || $urandom_range(0, 7) == 0);
      in_valid = iv;
      out_ready = rdy;
      @(posedge clk); #1;
      e++;
      if (acc < 16) begin
        if (iv) begin
          acc++;
          if (acc == 16) cend = e + 4 * STG;
        end
      end else if (cend >= 0 && e > cend && rd < 16 && rdy) begin
        rd++;
        if (rd == 16) begin
          dend = e + 1;
          sb.push_back('{8, 0, 0, 0, 0, 0, dend});
        end
      end
      if (mode == 3 && cend >= 0 && e == cend - 4 * STG + 9) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("mid_flush_reset");
        sb.delete();
        last_load = 0;
        last_a = 0;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        return;
      end
    end
    start = poke;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) chk("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    #12 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    run_frame(1, 1'b0);
    run_frame(2, 1'b1);
    for (int n = 0; n < 3; n++) run_frame(2, 1'($urandom_range(0, 1)));
    run_frame(3, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(2, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
